// File: rtl/seg_scan_pkg.sv
// Shared types, seven-segment pattern constants and the pattern-to-nibble decoder.
// Latency: combinational helpers only.
// Backpressure: not applicable.
package seg_scan_pkg;

    typedef logic [6:0] seg_pattern_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_HOLD  = 2'd2
    } dwell_state_t;

    // Active-low patterns, bit order {A,B,C,D,E,F,G} with A as MSB.
    localparam seg_pattern_t SEG_0 = 7'h01;
    localparam seg_pattern_t SEG_1 = 7'h4F;
    localparam seg_pattern_t SEG_2 = 7'h12;
    localparam seg_pattern_t SEG_3 = 7'h06;
    localparam seg_pattern_t SEG_4 = 7'h4C;
    localparam seg_pattern_t SEG_5 = 7'h24;
    localparam seg_pattern_t SEG_6 = 7'h20;
    localparam seg_pattern_t SEG_7 = 7'h0F;
    localparam seg_pattern_t SEG_8 = 7'h00;
    localparam seg_pattern_t SEG_9 = 7'h04;
    localparam seg_pattern_t SEG_A = 7'h08;
    localparam seg_pattern_t SEG_B = 7'h60;
    localparam seg_pattern_t SEG_C = 7'h31;
    localparam seg_pattern_t SEG_D = 7'h42;
    localparam seg_pattern_t SEG_E = 7'h30;
    localparam seg_pattern_t SEG_F = 7'h38;

    // Returns {err, nibble}; unknown patterns decode to nibble 0 with err set.
    function automatic logic [4:0] seg_to_nibble(input seg_pattern_t pat);
        logic [4:0] res;
        case (pat)
            SEG_0:   res = 5'h00;
            SEG_1:   res = 5'h01;
            SEG_2:   res = 5'h02;
            SEG_3:   res = 5'h03;
            SEG_4:   res = 5'h04;
            SEG_5:   res = 5'h05;
            SEG_6:   res = 5'h06;
            SEG_7:   res = 5'h07;
            SEG_8:   res = 5'h08;
            SEG_9:   res = 5'h09;
            SEG_A:   res = 5'h0A;
            SEG_B:   res = 5'h0B;
            SEG_C:   res = 5'h0C;
            SEG_D:   res = 5'h0D;
            SEG_E:   res = 5'h0E;
            SEG_F:   res = 5'h0F;
            default: res = 5'h10;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/seg_dwell_detector.sv
// Synchronises the scanned lines and emits one capture pulse per stable single-anode dwell.
// Latency: capture pulse STABLE_CYCLES+2 clocks after the lines settle.
// Backpressure: none; captures are fire-and-forget pulses.
module seg_dwell_detector
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  seg_pattern_t seg,
    input  logic         dp,
    input  logic [7:0]   an,
    output logic         cap_vld,
    output logic [2:0]   cap_idx,
    output seg_pattern_t cap_seg,
    output logic         cap_dp
);

    localparam logic [7:0] STABLE_LIM = 8'(STABLE_CYCLES);

    logic [15:0]  sync1;
    logic [15:0]  sync2;
    logic [15:0]  prev;
    dwell_state_t state;
    dwell_state_t state_nxt;
    logic [7:0]   cnt;
    logic [7:0]   cnt_nxt;
    logic         do_cap;
    logic [7:0]   nan;
    logic         single;
    logic         same;
    logic [2:0]   idx;

    // Two-flop synchroniser plus a one-cycle history for change detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
            prev  <= '0;
        end else begin
            sync1 <= {seg, dp, an};
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Single-anode detection and digit index from the synchronised anodes.
    always_comb begin
        nan    = ~sync2[7:0];
        single = (nan != 8'd0) && ((nan & (nan - 8'd1)) == 8'd0);
        same   = (sync2 == prev);
        idx    = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (nan[i]) idx = 3'(i);
        end
    end

    // Next-state logic; the capture fires on the edge where the count reaches the limit.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_cap    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (single) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = ST_TRACK;
                end
            end
            ST_TRACK: begin
                if (same) begin
                    cnt_nxt = cnt + 8'd1;
                end else if (single) begin
                    cnt_nxt = 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!same) begin
                    cnt_nxt   = 8'd1;
                    state_nxt = single ? ST_TRACK : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_TRACK && cnt_nxt == STABLE_LIM) begin
            do_cap    = 1'b1;
            state_nxt = ST_HOLD;
        end
    end

    // State, dwell counter and registered capture outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            cap_vld <= 1'b0;
            cap_idx <= '0;
            cap_seg <= '0;
            cap_dp  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            cap_vld <= do_cap;
            if (do_cap) begin
                cap_idx <= idx;
                cap_seg <= sync2[15:9];
                cap_dp  <= sync2[8];
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Decodes a scanned 8-digit seven-segment display back into frames; SEG_SCAN_TIMEOUT_EN adds a stale watchdog.
// Latency: frame_valid one clock after the eighth digit's capture pulse.
// Backpressure: frame held until frame_valid & frame_ready; a frame completing while one is pending is dropped and flags overrun.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
`ifdef SEG_SCAN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1_000_000
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  seg_pattern_t seg,
    input  logic         dp,
    input  logic [7:0]   an,
    output logic [31:0]  frame_digits,
    output logic [7:0]   frame_dp,
    output logic [7:0]   frame_err,
    output logic         frame_valid,
    input  logic         frame_ready,
    output logic         overrun
`ifdef SEG_SCAN_TIMEOUT_EN
    ,
    output logic         stale
`endif
);

    logic         cap_vld;
    logic [2:0]   cap_idx;
    seg_pattern_t cap_seg;
    logic         cap_dp;

    logic [31:0]  work_digits;
    logic [31:0]  work_digits_nxt;
    logic [7:0]   work_dp;
    logic [7:0]   work_dp_nxt;
    logic [7:0]   work_err;
    logic [7:0]   work_err_nxt;
    logic [7:0]   seen;
    logic [7:0]   seen_nxt;
    logic [4:0]   dec;
    logic         complete;
    logic         handshake;
    logic         wd_fire;

    seg_dwell_detector #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_dwell (
        .clk     (clk),
        .rst_n   (rst_n),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .cap_vld (cap_vld),
        .cap_idx (cap_idx),
        .cap_seg (cap_seg),
        .cap_dp  (cap_dp)
    );

    // Merge the current capture into the working frame so completion can copy it directly.
    always_comb begin
        dec             = seg_to_nibble(cap_seg);
        work_digits_nxt = work_digits;
        work_dp_nxt     = work_dp;
        work_err_nxt    = work_err;
        seen_nxt        = seen;
        if (cap_vld) begin
            work_digits_nxt[{cap_idx, 2'b00} +: 4] = dec[3:0];
            work_dp_nxt[cap_idx]                   = ~cap_dp;
            work_err_nxt[cap_idx]                  = dec[4];
            seen_nxt[cap_idx]                      = 1'b1;
        end
        complete  = cap_vld && (seen_nxt == 8'hFF);
        handshake = frame_valid && frame_ready;
    end

`ifdef SEG_SCAN_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign wd_fire = !cap_vld && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    // Watchdog: clocks since the last capture; expiry drops the partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else if (cap_vld) begin
            wd_cnt <= '0;
            stale  <= 1'b0;
        end else if (wd_fire) begin
            wd_cnt <= '0;
            stale  <= 1'b1;
        end else begin
            wd_cnt <= wd_cnt + 32'd1;
            stale  <= 1'b0;
        end
    end
`else
    assign wd_fire = 1'b0;
`endif

    // Working frame, seen mask, frame output register and handshake/overrun tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_digits  <= '0;
            work_dp      <= '0;
            work_err     <= '0;
            seen         <= '0;
            frame_digits <= '0;
            frame_dp     <= '0;
            frame_err    <= '0;
            frame_valid  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            work_digits <= work_digits_nxt;
            work_dp     <= work_dp_nxt;
            work_err    <= work_err_nxt;
            if (complete || wd_fire) begin
                seen <= '0;
            end else begin
                seen <= seen_nxt;
            end
            if (complete && (!frame_valid || handshake)) begin
                frame_digits <= work_digits_nxt;
                frame_dp     <= work_dp_nxt;
                frame_err    <= work_err_nxt;
                frame_valid  <= 1'b1;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (handshake) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with hand-computed frames.
// Latency: checks sampled on the falling edge.
// Backpressure: frame_ready driven per scenario.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;
    logic [31:0] frame_digits;
    logic [7:0]  frame_dp;
    logic [7:0]  frame_err;
    logic        frame_valid;
    logic        frame_ready;
    logic        overrun;

    int checks = 0;
    int errors = 0;

    int          vld_cycles = 0;
    int          hs_cnt = 0;
    int          cap_cnt = 0;
    logic [31:0] hs_digits = '0;
    logic [7:0]  hs_dp = '0;
    logic [7:0]  hs_err = '0;

    // Hand-written active-low pattern table, index = hex value.
    logic [6:0] pat_tab [0:15] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
                                   7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    always #5 clk = ~clk;

    seg_scan_decoder #(.STABLE_CYCLES(4)) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .seg          (seg),
        .dp           (dp),
        .an           (an),
        .frame_digits (frame_digits),
        .frame_dp     (frame_dp),
        .frame_err    (frame_err),
        .frame_valid  (frame_valid),
        .frame_ready  (frame_ready),
        .overrun      (overrun)
    );

    // Observe valid cycles, handshakes and capture pulses away from the rising edge.
    always @(negedge clk) begin
        if (frame_valid) vld_cycles++;
        if (frame_valid && frame_ready) begin
            hs_cnt++;
            hs_digits = frame_digits;
            hs_dp     = frame_dp;
            hs_err    = frame_err;
        end
        if (u_dut.cap_vld) cap_cnt++;
    end

    task automatic scan(input int digit, input logic [6:0] s, input logic d, input int n);
        an  = ~(8'd1 << digit);
        seg = s;
        dp  = d;
        repeat (n) @(negedge clk);
    endtask

    task automatic blank(input int n);
        an  = 8'hFF;
        seg = 7'h7F;
        dp  = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst_n       = 1'b0;
        frame_ready = 1'b1;
        blank(3);
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", frame_valid); end
        checks++; if (frame_digits !== 32'h0) begin errors++; $display("FAIL reset_digits got %h want 0", frame_digits); end
        checks++; if (frame_dp !== 8'h0) begin errors++; $display("FAIL reset_dp got %h want 0", frame_dp); end
        checks++; if (frame_err !== 8'h0) begin errors++; $display("FAIL reset_err got %h want 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
        rst_n = 1'b1;
        blank(3);
    endtask

    task automatic test_full_scan;
        int v0 = vld_cycles;
        int h0 = hs_cnt;
        int c0 = cap_cnt;
        for (int i = 0; i < 8; i++) scan(i, pat_tab[i], 1'b1, 10);
        blank(5);
        checks++; if (vld_cycles - v0 !== 1) begin errors++; $display("FAIL full_valid_pulses got %0d want 1", vld_cycles - v0); end
        checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL full_handshakes got %0d want 1", hs_cnt - h0); end
        checks++; if (cap_cnt - c0 !== 8) begin errors++; $display("FAIL full_captures got %0d want 8", cap_cnt - c0); end
        checks++; if (hs_digits !== 32'h76543210) begin errors++; $display("FAIL full_digits got %h want 76543210", hs_digits); end
        checks++; if (hs_err !== 8'h00) begin errors++; $display("FAIL full_err got %h want 00", hs_err); end
        checks++; if (hs_dp !== 8'h00) begin errors++; $display("FAIL full_dp got %h want 00", hs_dp); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL full_valid_drop got %b want 0", frame_valid); end
    endtask

    task automatic test_short_dwell;
        int c0 = cap_cnt;
        int c1;
        int v0;
        scan(2, 7'h12, 1'b1, 3);
        blank(3);
        checks++; if (cap_cnt - c0 !== 0) begin errors++; $display("FAIL short_dwell_none got %0d want 0", cap_cnt - c0); end
        scan(2, 7'h12, 1'b1, 10);
        blank(3);
        checks++; if (cap_cnt - c0 !== 1) begin errors++; $display("FAIL short_then_long got %0d want 1", cap_cnt - c0); end
        c1 = cap_cnt;
        scan(2, 7'h12, 1'b1, 40);
        blank(3);
        checks++; if (cap_cnt - c1 !== 1) begin errors++; $display("FAIL long_dwell_once got %0d want 1", cap_cnt - c1); end
        v0 = vld_cycles;
        scan(0, pat_tab[8], 1'b1, 10);
        scan(1, pat_tab[9], 1'b1, 10);
        for (int i = 3; i < 8; i++) scan(i, pat_tab[7 + i], 1'b1, 10);
        blank(5);
        checks++; if (vld_cycles - v0 !== 1) begin errors++; $display("FAIL short_frame_pulses got %0d want 1", vld_cycles - v0); end
        checks++; if (hs_digits !== 32'hEDCBA298) begin errors++; $display("FAIL short_frame_digits got %h want EDCBA298", hs_digits); end
    endtask

    task automatic test_err_dp;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) scan(i, 7'h7F, 1'b1, 10);
            else scan(i, pat_tab[i], (i == 0) ? 1'b0 : 1'b1, 10);
        end
        blank(5);
        checks++; if (hs_err !== 8'h20) begin errors++; $display("FAIL err_mask got %h want 20", hs_err); end
        checks++; if (hs_dp !== 8'h01) begin errors++; $display("FAIL dp_mask got %h want 01", hs_dp); end
        checks++; if (hs_digits !== 32'h76043210) begin errors++; $display("FAIL err_digits got %h want 76043210", hs_digits); end
    endtask

    task automatic test_multi_anode;
        int c0;
        int v0 = vld_cycles;
        for (int i = 0; i < 4; i++) scan(i, pat_tab[15 - i], 1'b1, 10);
        c0 = cap_cnt;
        an  = 8'b1111_1100;
        seg = pat_tab[0];
        dp  = 1'b1;
        repeat (20) @(negedge clk);
        checks++; if (cap_cnt - c0 !== 0) begin errors++; $display("FAIL multi_anode_capture got %0d want 0", cap_cnt - c0); end
        checks++; if (u_dut.seen !== 8'h0F) begin errors++; $display("FAIL multi_anode_seen got %h want 0f", u_dut.seen); end
        for (int i = 4; i < 8; i++) scan(i, pat_tab[15 - i], 1'b1, 10);
        blank(5);
        checks++; if (vld_cycles - v0 !== 1) begin errors++; $display("FAIL multi_frame_pulses got %0d want 1", vld_cycles - v0); end
        checks++; if (hs_digits !== 32'h89ABCDEF) begin errors++; $display("FAIL multi_frame_digits got %h want 89abcdef", hs_digits); end
    endtask

    task automatic test_overrun;
        int h0;
        frame_ready = 1'b0;
        for (int i = 0; i < 8; i++) scan(i, pat_tab[i], 1'b1, 10);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid got %b want 1", frame_valid); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_before got %b want 0", overrun); end
        for (int i = 0; i < 8; i++) scan(i, pat_tab[8 + i], 1'b1, 10);
        blank(3);
        checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL ovr_held_valid got %b want 1", frame_valid); end
        checks++; if (frame_digits !== 32'h76543210) begin errors++; $display("FAIL ovr_held_digits got %h want 76543210", frame_digits); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set got %b want 1", overrun); end
        h0 = hs_cnt;
        @(posedge clk);
        #1 frame_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (hs_cnt - h0 !== 1) begin errors++; $display("FAIL ovr_handshake got %0d want 1", hs_cnt - h0); end
        checks++; if (hs_digits !== 32'h76543210) begin errors++; $display("FAIL ovr_hs_digits got %h want 76543210", hs_digits); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL ovr_valid_drop got %b want 0", frame_valid); end
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b want 1", overrun); end
        blank(3);
    endtask

    task automatic test_reset_mid;
        int v0;
        for (int i = 0; i < 4; i++) scan(i, pat_tab[i], 1'b1, 10);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rstmid_overrun got %b want 0", overrun); end
        checks++; if (u_dut.seen !== 8'h00) begin errors++; $display("FAIL rstmid_seen got %h want 00", u_dut.seen); end
        checks++; if (frame_digits !== 32'h0) begin errors++; $display("FAIL rstmid_digits got %h want 0", frame_digits); end
        rst_n = 1'b1;
        blank(3);
        v0 = vld_cycles;
        for (int i = 4; i < 8; i++) scan(i, pat_tab[i], 1'b1, 10);
        blank(5);
        checks++; if (vld_cycles - v0 !== 0) begin errors++; $display("FAIL rstmid_no_frame got %0d want 0", vld_cycles - v0); end
        checks++; if (frame_digits !== 32'h0) begin errors++; $display("FAIL rstmid_after_digits got %h want 0", frame_digits); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after_valid got %b want 0", frame_valid); end
        v0 = vld_cycles;
        for (int i = 0; i < 8; i++) scan(i, pat_tab[i], 1'b1, 10);
        blank(5);
        checks++; if (vld_cycles - v0 !== 1) begin errors++; $display("FAIL rstmid_full_pulses got %0d want 1", vld_cycles - v0); end
        checks++; if (hs_digits !== 32'h76543210) begin errors++; $display("FAIL rstmid_full_digits got %h want 76543210", hs_digits); end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_ready = 1'b1;
        an          = 8'hFF;
        seg         = 7'h7F;
        dp          = 1'b1;
        @(negedge clk);
        test_reset;
        test_full_scan;
        test_short_dwell;
        test_err_dp;
        test_multi_anode;
        test_overrun;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the 8-digit multiplexed seven-segment driver (num/sel → A..G, DP, AN).
- Samples the live scanned segment/anode lines, finds each stable digit dwell, and decodes each active-low segment pattern back to a hex nibble.
- Assembles all eight digits into a frame and offers it on a valid/ready handshake.
- Used for loopback self-check on board and as a bench scoreboard source.

Parameters:
- STABLE_CYCLES, 4: consecutive clocks the anode/segment lines must hold unchanged before a digit is captured (1..255).
- TIMEOUT_CYCLES, 1_000_000: watchdog limit. Used only with SEG_SCAN_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- seg  in  7  segment lines {A,B,C,D,E,F,G}, A = MSB, active-low (0 = lit).
- dp  in  1  decimal point, active-low.
- an  in  8  anode lines, active-low. an[i] = digit i.
- frame_digits  out  32  nibble i at bits [4i+3:4i].
- frame_dp  out  8  bit i = DP lit on digit i.
- frame_err  out  8  bit i = digit i pattern not in decode table.
- frame_valid  out  1  frame offered.
- frame_ready  in  1  consumer accepts.
- overrun  out  1  sticky: a frame completed while the previous one was still pending.

Behaviour:
- Reset: all outputs 0, seen mask 0, FSM = IDLE.
- Input registration: seg, dp, an pass through a 2-flop synchroniser. All comparisons use the synchronised values.
- Single-anode test: exactly one bit of an is 0.
- FSM:
  - IDLE: if single-anode, load dwell counter = 1 and go to TRACK.
  - TRACK: if {seg,dp,an} equals the previous cycle, increment the counter; otherwise restart at 1 (or go to IDLE if no longer single-anode). When counter == STABLE_CYCLES, capture the digit and go to HOLD.
  - HOLD: stay until {seg,dp,an} changes. Then go to TRACK if single-anode, else IDLE.
  - Only one capture per dwell; long dwells never recapture.
- Zero or multiple anodes low: no capture, FSM returns to IDLE.
- Capture of digit i: write the nibble, dp_i = ~dp, err_i, and set seen[i]. A later capture of the same digit overwrites it.
- Decode table (active-low pattern → nibble):
  - 0x01→0, 0x4F→1, 0x12→2, 0x06→3, 0x4C→4, 0x24→5, 0x20→6, 0x0F→7
  - 0x00→8, 0x04→9, 0x08→A, 0x60→b, 0x31→C, 0x42→d, 0x30→E, 0x38→F
  - Any other pattern: nibble = 0, err = 1.
- Frame completion: when seen == 8'hFF after a capture:
  - Copy the working registers to the frame outputs and clear seen in the same cycle.
  - frame_valid asserts the next cycle.
- Handshake:
  - frame_valid and the frame outputs hold stable until frame_valid & frame_ready.
  - frame_valid drops the cycle after the handshake.
  - If a new frame completes while frame_valid=1 and no handshake occurs that cycle, set overrun and discard the new frame.
  - A simultaneous handshake and completion loads the new frame; frame_valid stays 1.
- Latency: the first capture occurs STABLE_CYCLES+2 clocks after a digit's lines settle (2 synchroniser stages).
- overrun clears only on reset.
- Reset asserted mid-dwell or mid-frame: everything clears immediately. No partial frame survives.

Optional Feature:
- Macro SEG_SCAN_TIMEOUT_EN.
- Defined:
  - A watchdog counts clocks since the last capture.
  - On reaching TIMEOUT_CYCLES, it clears seen and emits a 1-cycle pulse on the extra output port stale (1 bit).
  - Any capture resets the count.
- Undefined: no counter, no stale port. The partial frame waits indefinitely.

Decomposition:
- Package seg_scan_pkg holds:
  - the segment pattern constants SEG_0..SEG_F;
  - the typedef seg_pattern_t (logic [6:0]);
  - function seg_to_nibble returning {err, nibble[3:0]}.
- One sub-module, seg_dwell_detector: the synchroniser, stability counter and IDLE/TRACK/HOLD FSM. It outputs a capture pulse plus digit index, pattern and dp.
- The top does decode, frame assembly and the handshake.

Test Plan (STABLE_CYCLES=4, frame_ready=1 unless stated):
- Scan digits 0..7 with patterns for 0..7 (an[i]=0, 10-clock dwell each) → one frame_valid pulse; frame_digits=32'h76543210, frame_err=0, frame_dp=0.
- Dwell of only 3 clocks on digit 2 (pattern 0x12), then 10 clocks → exactly one capture, nibble 2. A 40-clock dwell also yields one capture.
- Pattern 0x7F on digit 5, dp=0 on digit 0, others valid → frame_err=8'h20, frame_dp=8'h01, nibble 5 = 0.
- an=8'b1111_1100 for 20 clocks mid-scan → no capture, seen unchanged. Resuming the scan completes the frame normally.
- frame_ready=0, two full frames scanned → first frame held stable, overrun=1 after second completion. Raising frame_ready → handshake, frame_valid=0 next cycle, overrun stays 1.
- rst_n pulsed low after 4 digits captured, then 4 digits scanned → no frame_valid; all outputs 0 during and after reset until a full 8-digit scan.
